fetch_byte_queue: RTL and testbench
===================================

// Module: fetch_byte_queue
// PURPOSE
// - Instruction-byte ring buffer. It is the producer end of the decoder's byte interface.
// - Accepts 8-byte fetch beats from the I-side memory port.
// - Presents a 15-byte, MSB-first window plus its PC to the decode stage.
// - Retires exactly the byte count the decoder returns for each decoded instruction.
// - Sits between the fetch unit and the decoder; the redirect port serves branch/flush recovery.
// PARAMETERS
// - DEPTH_BYTES   32  ring capacity in bytes; power of two, >= 2*FILL_BYTES
// - FILL_BYTES     8  bytes per fill beat
// - WINDOW_BYTES  15  bytes presented to the decoder (max x86 instruction length)
// PORTS
// - clk             in   1    clock
// - reset_n         in   1    asynchronous, active-low reset
// - redirect_valid  in   1    flush queue and restart at redirect_pc
// - redirect_pc     in   64   new fetch/decode PC
// - fill_valid      in   1    fill beat offered
// - fill_ready      out  1    queue can accept a full beat this cycle
// - fill_data       in   64   beat bytes; byte 0 (lowest address) in [63:56]
// - dc_bytes        out  120  window, logic[0:119]; byte i at bits [8i:8i+7]
// - dc_pc           out  64   address of dc_bytes byte 0
// - dc_avail        out  4    valid window bytes, min(count,15)
// - dc_full         out  1    dc_avail == 15
// - consume_valid   in   1    decoder retires one instruction
// - consume_len     in   4    its length in bytes, 1..15
// - consume_err     out  1    sticky: illegal consume seen
// BEHAVIOUR
// - State: rd_ptr, wr_ptr (log2 DEPTH_BYTES), count (0..DEPTH_BYTES), pc (64), err.
// - Reset (async, reset_n=0) clears everything:
//   - ptrs=0, count=0, pc=0, err=0
//   - outputs: dc_bytes=0, dc_pc=0, dc_avail=0, dc_full=0, consume_err=0
//   - fill_ready=1 after reset.
// - A reset mid-operation drops all buffered bytes.
// - Outputs are decoded from registered state only (no same-cycle bypass).
//   - A fill or consume is visible in dc_* the following cycle.
// - dc_bytes byte i = ring[(rd_ptr+i) mod DEPTH] for i < dc_avail, else 8'h00.
//   - Wrap-around is seamless.
// - fill_ready = !redirect_valid && (DEPTH_BYTES - count) >= FILL_BYTES.
// - Fill accepted iff fill_valid && fill_ready:
//   - write 8 bytes at wr_ptr (mod DEPTH)
//   - wr_ptr += 8, count += 8
// - Consume is legal iff consume_valid && 1 <= consume_len <= dc_avail. On a legal consume:
//   - rd_ptr += len, count -= len
//   - pc += zero-extended len, modulo 2^64
// - Illegal consume (len==0 or len>dc_avail):
//   - no state change
//   - err <= 1, sticky until reset.
// - Fill and consume in the same cycle: count_next = count + 8 - len; both pointers advance.
// - Redirect has priority over all else:
//   - ptrs=0, count=0, pc=redirect_pc
//   - a concurrent consume is ignored, and is not an error
//   - fill_ready is 0, so no fill is taken.
// - Full: count > DEPTH-8 forces fill_ready=0.
// - Empty: dc_avail=0, so any consume is illegal.
// CONFIGURATION
// - FBQ_STATS_EN defined adds two ports:
//   - stat_insts out 32: counts legal consumes.
//   - stat_starve out 32: counts cycles with !dc_full && !redirect_valid.
//   - Both reset to 0 and wrap at 2^32.
// - FBQ_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
// - Reset, then redirect pc=0x1000.
//   - Fill 0x0F1F440000909090, then 0x48B8112233445566.
//   - Next cycle: dc_pc=0x1000, dc_avail=15, dc_full=1.
//   - dc_bytes = 0F 1F 44 00 00 90 90 90 48 B8 11 22 33 44 55.
// - Consume len=5.
//   - dc_pc=0x1005, dc_avail=11.
//   - dc_bytes[0:7]=0x90.
//   - Bytes 11..14 are zero.
// - Fill 4 beats (count=32): fill_ready=0.
//   - Consume 3: fill_ready=0 (count 29 > 24).
//   - Consume 5 more (count 24): fill_ready=1.
//   - Window crosses ptr 31->0 with correct bytes.
// - Same-cycle fill + consume len=7 at count=16: count becomes 17 next cycle, dc_avail=15.
// - Consume len=9 with dc_avail=4:
//   - consume_err=1, dc_pc unchanged.
//   - Then redirect 0x2000: count=0, dc_pc=0x2000, consume_err stays 1.
// - Assert reset_n low mid-stream with count=20: all outputs 0 immediately.
//   - With FBQ_STATS_EN, stat_insts=0.

Source files
------------

// File: rtl/fetch_byte_queue.sv
// Instruction-byte ring buffer: takes 8-byte fetch beats and presents a 15-byte MSB-first window plus PC to decode.
// Optional FBQ_STATS_EN adds stat_insts / stat_starve counters.
module fetch_byte_queue #(
    parameter int DEPTH_BYTES  = 32,
    parameter int FILL_BYTES   = 8,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    input  logic                      fill_valid,
    output logic                      fill_ready,
    input  logic [8*FILL_BYTES-1:0]   fill_data,
    output logic [0:8*WINDOW_BYTES-1] dc_bytes,
    output logic [63:0]               dc_pc,
    output logic [3:0]                dc_avail,
    output logic                      dc_full,
    input  logic                      consume_valid,
    input  logic [3:0]                consume_len,
    output logic                      consume_err
`ifdef FBQ_STATS_EN
    ,
    output logic [31:0]               stat_insts,
    output logic [31:0]               stat_starve
`endif
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [63:0]      pc;
    logic             err;
    logic [7:0]       ring [DEPTH_BYTES];

    logic [3:0] avail;
    logic       len_ok;
    logic       fill_fire;
    logic       consume_ok;
    logic       consume_bad;

    // Handshakes: a fill beat transfers on any cycle with fill_valid && fill_ready;
    // consume_valid is always taken and judged against the current dc_avail,
    // with redirect overriding both (no fill accepted, consume ignored).
    always_comb begin
        avail       = (count >= CNT_W'(WINDOW_BYTES)) ? 4'(WINDOW_BYTES) : count[3:0];
        len_ok      = (consume_len != 4'd0) && (consume_len <= avail);
        fill_ready  = !redirect_valid && (count <= CNT_W'(DEPTH_BYTES - FILL_BYTES));
        fill_fire   = fill_valid && fill_ready;
        consume_ok  = consume_valid && !redirect_valid && len_ok;
        consume_bad = consume_valid && !redirect_valid && !len_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= '0;
            err    <= 1'b0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            pc     <= redirect_pc;
        end else begin
            if (fill_fire)
                wr_ptr <= wr_ptr + PTR_W'(FILL_BYTES);
            if (consume_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(consume_len);
                pc     <= pc + 64'(consume_len);
            end
            count <= count + (fill_fire ? CNT_W'(FILL_BYTES) : '0)
                           - (consume_ok ? CNT_W'(consume_len) : '0);
            if (consume_bad)
                err <= 1'b1;
        end
    end

    // Ring storage needs no reset: bytes beyond count are masked off the window.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            for (int k = 0; k < FILL_BYTES; k++)
                ring[wr_ptr + PTR_W'(k)] <= fill_data[(FILL_BYTES-1-k)*8 +: 8];
        end
    end

    always_comb begin
        dc_bytes = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (i < int'(avail))
                dc_bytes[8*i +: 8] = ring[rd_ptr + PTR_W'(i)];
        end
        dc_pc       = pc;
        dc_avail    = avail;
        dc_full     = (avail == 4'(WINDOW_BYTES));
        consume_err = err;
    end

`ifdef FBQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_insts  <= '0;
            stat_starve <= '0;
        end else begin
            if (consume_ok)
                stat_insts <= stat_insts + 32'd1;
            if (!dc_full && !redirect_valid)
                stat_starve <= stat_starve + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: directed scenarios then random traffic, checked against a byte-queue model.
module tb_fetch_byte_queue;

    logic         clk;
    logic         reset_n;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         fill_valid;
    logic         fill_ready;
    logic [63:0]  fill_data;
    logic [0:119] dc_bytes;
    logic [63:0]  dc_pc;
    logic [3:0]   dc_avail;
    logic         dc_full;
    logic         consume_valid;
    logic [3:0]   consume_len;
    logic         consume_err;
`ifdef FBQ_STATS_EN
    logic [31:0]  stat_insts;
    logic [31:0]  stat_starve;
`endif

    fetch_byte_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fill_valid     (fill_valid),
        .fill_ready     (fill_ready),
        .fill_data      (fill_data),
        .dc_bytes       (dc_bytes),
        .dc_pc          (dc_pc),
        .dc_avail       (dc_avail),
        .dc_full        (dc_full),
        .consume_valid  (consume_valid),
        .consume_len    (consume_len),
        .consume_err    (consume_err)
`ifdef FBQ_STATS_EN
        ,
        .stat_insts     (stat_insts),
        .stat_starve    (stat_starve)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: the buffered bytes in order, oldest first.
    logic [7:0]  mq[$];
    logic [63:0] m_pc;
    logic        m_err;
    logic [31:0] m_insts;
    logic [31:0] m_starve;

    function automatic int m_avail();
        return (mq.size() > 15) ? 15 : mq.size();
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = '0;
        m_err    = 1'b0;
        m_insts  = '0;
        m_starve = '0;
    endtask

    task automatic check_all();
        logic [0:119] e;
        e = '0;
        for (int i = 0; i < m_avail(); i++) e[8*i +: 8] = mq[i];
        chk("dc_bytes", dc_bytes, e);
        chk("dc_pc", dc_pc, m_pc);
        chk("dc_avail", dc_avail, m_avail());
        chk("dc_full", dc_full, m_avail() == 15);
        chk("fill_ready", fill_ready, !redirect_valid && (32 - mq.size()) >= 8);
        chk("consume_err", consume_err, m_err);
`ifdef FBQ_STATS_EN
        chk("stat_insts", stat_insts, m_insts);
        chk("stat_starve", stat_starve, m_starve);
`endif
    endtask

    task automatic model_step(input logic rv, input logic [63:0] rpc, input logic fv,
                              input logic [63:0] fd, input logic cv, input logic [3:0] cl);
        int n;
        int av;
        n  = mq.size();
        av = (n > 15) ? 15 : n;
        if (av != 15 && !rv) m_starve++;
        if (rv) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            if (cv && cl >= 1 && int'(cl) <= av) begin
                for (int k = 0; k < int'(cl); k++) mq.delete(0);
                m_pc = m_pc + 64'(cl);
                m_insts++;
            end else if (cv) begin
                m_err = 1'b1;
            end
            if (fv && (32 - n) >= 8)
                for (int k = 0; k < 8; k++) mq.push_back(fd[63-8*k -: 8]);
        end
    endtask

    // Drive one cycle from a negedge: check pre-edge outputs, clock, advance the model.
    task automatic cycle(input logic rv, input logic [63:0] rpc, input logic fv,
                         input logic [63:0] fd, input logic cv, input logic [3:0] cl);
        redirect_valid = rv;
        redirect_pc    = rpc;
        fill_valid     = fv;
        fill_data      = fd;
        consume_valid  = cv;
        consume_len    = cl;
        #1;
        check_all();
        @(posedge clk);
        model_step(rv, rpc, fv, fd, cv, cl);
        @(negedge clk);
        redirect_valid = 1'b0;
        fill_valid     = 1'b0;
        consume_valid  = 1'b0;
        consume_len    = 4'd0;
    endtask

    task automatic idle();
        cycle(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 4'd0);
    endtask

    task automatic redirect(input logic [63:0] rpc);
        cycle(1'b1, rpc, 1'b0, 64'h0, 1'b0, 4'd0);
    endtask

    task automatic fill(input logic [63:0] fd);
        cycle(1'b0, 64'h0, 1'b1, fd, 1'b0, 4'd0);
    endtask

    task automatic consume(input logic [3:0] cl);
        cycle(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, cl);
    endtask

    initial begin
        logic [119:0] win_exp;
        logic [63:0]  pc_hold;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fill_valid     = 1'b0;
        fill_data      = '0;
        consume_valid  = 1'b0;
        consume_len    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_dc_bytes", dc_bytes, 120'h0);
        chk("rst_dc_pc", dc_pc, 64'h0);
        chk("rst_dc_avail", dc_avail, 4'd0);
        chk("rst_dc_full", dc_full, 1'b0);
        chk("rst_consume_err", consume_err, 1'b0);
        chk("rst_fill_ready", fill_ready, 1'b1);
        reset_n = 1'b1;

        // Two beats after a redirect fill the window exactly.
        redirect(64'h1000);
        fill(64'h0F1F440000909090);
        fill(64'h48B8112233445566);
        #1;
        win_exp = 120'h0F1F440000909090_48B81122334455;
        chk("win_pc", dc_pc, 64'h1000);
        chk("win_avail", dc_avail, 4'd15);
        chk("win_full", dc_full, 1'b1);
        chk("win_bytes", dc_bytes, win_exp);
        consume(4'd5);
        #1;
        chk("c5_pc", dc_pc, 64'h1005);
        chk("c5_avail", dc_avail, 4'd11);
        chk("c5_byte0", dc_bytes[0:7], 8'h90);
        chk("c5_tail_zero", dc_bytes[88:119], 32'h0);

        // Full threshold and wrap of the window across ring index 31 -> 0.
        redirect(64'h3000);
        for (int b = 0; b < 4; b++) fill({$urandom, $urandom});
        #1 chk("full_ready", fill_ready, 1'b0);
        consume(4'd3);
        #1 chk("c29_ready", fill_ready, 1'b0);
        consume(4'd5);
        #1 chk("c24_ready", fill_ready, 1'b1);
        fill({$urandom, $urandom});
        consume(4'd15);
        consume(4'd4);
        idle();
        consume(4'd9);
        idle();

        // Simultaneous fill and consume at count 16 leaves 17 bytes.
        redirect(64'h4000);
        fill({$urandom, $urandom});
        fill({$urandom, $urandom});
        cycle(1'b0, 64'h0, 1'b1, {$urandom, $urandom}, 1'b1, 4'd7);
        #1 chk("fc_avail", dc_avail, 4'd15);
        consume(4'd2);
        #1 chk("fc_after_avail", dc_avail, 4'd15);
        consume(4'd1);
        #1 chk("fc_count14", dc_avail, 4'd14);

        // Over-long consume flags a sticky error that survives a redirect.
        redirect(64'h5000);
        fill({$urandom, $urandom});
        consume(4'd4);
        pc_hold = 64'h5004;
        consume(4'd9);
        #1;
        chk("err_set", consume_err, 1'b1);
        chk("err_pc_hold", dc_pc, pc_hold);
        chk("err_avail_hold", dc_avail, 4'd4);
        cycle(1'b1, 64'h2000, 1'b0, 64'h0, 1'b1, 4'd3);
        #1;
        chk("redir_pc", dc_pc, 64'h2000);
        chk("redir_avail", dc_avail, 4'd0);
        chk("redir_err", consume_err, 1'b1);
        consume(4'd0);

        // Asynchronous reset mid-stream with 20 bytes buffered.
        redirect(64'h6000);
        for (int b = 0; b < 3; b++) fill({$urandom, $urandom});
        consume(4'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_bytes", dc_bytes, 120'h0);
        chk("mrst_pc", dc_pc, 64'h0);
        chk("mrst_avail", dc_avail, 4'd0);
        chk("mrst_full", dc_full, 1'b0);
        chk("mrst_err", consume_err, 1'b0);
        chk("mrst_ready", fill_ready, 1'b1);
`ifdef FBQ_STATS_EN
        chk("mrst_insts", stat_insts, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic       rv;
            logic       fv;
            logic       cv;
            logic [3:0] cl;
            rv = ($urandom_range(0, 24) == 0);
            fv = ($urandom_range(0, 2) != 0);
            cv = ($urandom_range(0, 1) == 1);
            cl = ($urandom_range(0, 40) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
            cycle(rv, {$urandom, $urandom}, fv, {$urandom, $urandom}, cv, cl);
        end
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
